// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types for pipeline_hazard_ctrl: FSM state encoding, pipeline control bundle
// and a saturating-increment helper for the optional performance counters.
package pipeline_hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        HZ_RUN      = 2'b00,
        HZ_MEM_WAIT = 2'b01,
        HZ_REDIRECT = 2'b10
    } hz_state_e;

    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic pc_hold;
        logic if_id_hold;
        logic if_id_flush;
        logic id_ex_hold;
        logic pl_stall;
        logic pl_flush;
        logic ex_mem_hold;
        logic mem_wb_bubble;
    } hz_ctrl_t;

    localparam hz_ctrl_t CTRL_IDLE = '0;

    // Whole pipeline frozen behind MEM; MEM/WB receives a bubble.
    localparam hz_ctrl_t CTRL_MEM_HOLD = '{
        pc_hold: 1'b1, if_id_hold: 1'b1, if_id_flush: 1'b0, id_ex_hold: 1'b1,
        pl_stall: 1'b0, pl_flush: 1'b0, ex_mem_hold: 1'b1, mem_wb_bubble: 1'b1
    };

    function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
        return (en && (v != 32'hFFFF_FFFF)) ? v + 32'd1 : v;
    endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_load_use_det.sv
// Load-use hazard detector: a load in EX whose destination is read by the instruction in ID.
module hazard_load_use_det
    import pipeline_hazard_ctrl_pkg::*;
(
    input  logic [4:0] i_rs1,
    input  logic [4:0] i_rs2,
    input  logic       i_rs1_used,
    input  logic       i_rs2_used,
    input  logic [4:0] i_rd,
    input  logic       i_mem_read,
    output logic       o_load_use
);

    logic w_rs1_hit;
    logic w_rs2_hit;

    assign w_rs1_hit  = i_rs1_used && (i_rd == i_rs1);
    assign w_rs2_hit  = i_rs2_used && (i_rd == i_rs2);
    // x0 is never written, so a load targeting it cannot create a dependency.
    assign o_load_use = i_mem_read && (i_rd != REG_ZERO) && (w_rs1_hit || w_rs2_hit);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hold/bubble/flush controller for the 5-stage core (dmem wait > redirect > load-use).
// Optional macro HAZARD_PERF_CNT_EN adds saturating stall/flush/mem-wait performance counters.
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int REDIRECT_HOLD = 0,
    parameter int MEM_TIMEOUT   = 64,
    parameter int CW            = 7
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  Rs1_if_id,
    input  logic [4:0]  Rs2_if_id,
    input  logic        rs1_used,
    input  logic        rs2_used,
    input  logic [4:0]  Rd_id_ex,
    input  logic        MemRead_id_ex,
    input  logic        ex_redirect,
    input  logic        mem_req,
    input  logic        dmem_ready,
    output logic        pc_hold,
    output logic        if_id_hold,
    output logic        if_id_flush,
    output logic        id_ex_hold,
    output logic        PL_stall,
    output logic        PL_flush,
    output logic        ex_mem_hold,
    output logic        mem_wb_bubble,
    output logic        mem_timeout_err
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0] perf_stall_cnt,
    output logic [31:0] perf_flush_cnt,
    output logic [31:0] perf_memwait_cnt
`endif
);

    hz_state_e         r_state;
    logic [CW-1:0]     r_cnt;
    logic              r_err;
    logic              r_out_en;

    hz_state_e         w_state_nxt;
    logic [CW-1:0]     w_cnt_nxt;
    logic              w_err_set;
    logic              w_dispatch;
    logic              w_run_en;
    logic              w_mem_miss;
    logic              w_load_use;
    hz_ctrl_t          w_ctrl;

    hazard_load_use_det u_load_use (
        .i_rs1      (Rs1_if_id),
        .i_rs2      (Rs2_if_id),
        .i_rs1_used (rs1_used),
        .i_rs2_used (rs2_used),
        .i_rd       (Rd_id_ex),
        .i_mem_read (MemRead_id_ex),
        .o_load_use (w_load_use)
    );

    // Outputs stay quiet during reset and for the first cycle after it.
    assign w_run_en   = rst_n && r_out_en;
    assign w_mem_miss = mem_req && !dmem_ready;

    always_comb begin
        // NOTE: every signal gets a default first, so no path can infer a latch.
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_err_set   = 1'b0;
        w_dispatch  = 1'b0;
        w_ctrl      = CTRL_IDLE;

        if (w_run_en) begin
            if (r_state == HZ_MEM_WAIT) begin
                if (dmem_ready || (r_cnt == CW'(MEM_TIMEOUT))) begin
                    w_err_set   = !dmem_ready;
                    w_state_nxt = HZ_RUN;
                    w_cnt_nxt   = '0;
                    w_dispatch  = 1'b1;   // frozen EX/ID hazards are taken on release
                end else begin
                    w_ctrl    = CTRL_MEM_HOLD;
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end else begin
                w_dispatch = 1'b1;
            end
        end

        if (w_dispatch) begin
            if (w_mem_miss && (r_state != HZ_MEM_WAIT)) begin
                w_ctrl      = CTRL_MEM_HOLD;
                w_state_nxt = HZ_MEM_WAIT;
                w_cnt_nxt   = CW'(1);
            end else if (ex_redirect) begin
                w_ctrl.if_id_flush = 1'b1;
                w_ctrl.pl_flush    = 1'b1;
                if (REDIRECT_HOLD == 0) begin
                    w_state_nxt = HZ_RUN;
                    w_cnt_nxt   = '0;
                end else begin
                    w_state_nxt = HZ_REDIRECT;
                    w_cnt_nxt   = CW'(REDIRECT_HOLD);
                end
            end else if (r_state == HZ_REDIRECT) begin
                w_ctrl.if_id_flush = 1'b1;
                w_cnt_nxt          = r_cnt - CW'(1);
                if (r_cnt <= CW'(1)) begin
                    w_state_nxt = HZ_RUN;
                    w_cnt_nxt   = '0;
                end
            end else if (w_load_use) begin
                w_ctrl.pc_hold    = 1'b1;
                w_ctrl.if_id_hold = 1'b1;
                w_ctrl.pl_stall   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (!rst_n) begin
            r_state  <= HZ_RUN;
            r_cnt    <= '0;
            r_err    <= 1'b0;
            r_out_en <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_out_en <= 1'b1;
            if (w_err_set) begin
                r_err <= 1'b1;
            end
        end
    end

    assign pc_hold         = w_ctrl.pc_hold;
    assign if_id_hold      = w_ctrl.if_id_hold;
    assign if_id_flush     = w_ctrl.if_id_flush;
    assign id_ex_hold      = w_ctrl.id_ex_hold;
    assign PL_stall        = w_ctrl.pl_stall;
    assign PL_flush        = w_ctrl.pl_flush;
    assign ex_mem_hold     = w_ctrl.ex_mem_hold;
    assign mem_wb_bubble   = w_ctrl.mem_wb_bubble;
    assign mem_timeout_err = r_err && rst_n;

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] r_perf_stall;
    logic [31:0] r_perf_flush;
    logic [31:0] r_perf_memwait;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_perf_stall   <= '0;
            r_perf_flush   <= '0;
            r_perf_memwait <= '0;
        end else begin
            r_perf_stall   <= sat_inc(r_perf_stall, w_ctrl.pl_stall);
            r_perf_flush   <= sat_inc(r_perf_flush, w_ctrl.pl_flush);
            r_perf_memwait <= sat_inc(r_perf_memwait, w_run_en && (r_state == HZ_MEM_WAIT));
        end
    end

    assign perf_stall_cnt   = rst_n ? r_perf_stall   : '0;
    assign perf_flush_cnt   = rst_n ? r_perf_flush   : '0;
    assign perf_memwait_cnt = rst_n ? r_perf_memwait : '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: directed vector table, then randomized cycles vs a behavioural model.
module tb_pipeline_hazard_ctrl;

    localparam int REDIRECT_HOLD = 2;
    localparam int MEM_TIMEOUT   = 8;
    localparam int CW            = 4;

    logic       clk;
    logic       rst_n;
    logic [4:0] Rs1_if_id, Rs2_if_id, Rd_id_ex;
    logic       rs1_used, rs2_used, MemRead_id_ex, ex_redirect, mem_req, dmem_ready;
    logic       pc_hold, if_id_hold, if_id_flush, id_ex_hold;
    logic       PL_stall, PL_flush, ex_mem_hold, mem_wb_bubble, mem_timeout_err;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] perf_stall_cnt, perf_flush_cnt, perf_memwait_cnt;
`endif

    pipeline_hazard_ctrl #(
        .REDIRECT_HOLD (REDIRECT_HOLD),
        .MEM_TIMEOUT   (MEM_TIMEOUT),
        .CW            (CW)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .Rs1_if_id       (Rs1_if_id),
        .Rs2_if_id       (Rs2_if_id),
        .rs1_used        (rs1_used),
        .rs2_used        (rs2_used),
        .Rd_id_ex        (Rd_id_ex),
        .MemRead_id_ex   (MemRead_id_ex),
        .ex_redirect     (ex_redirect),
        .mem_req         (mem_req),
        .dmem_ready      (dmem_ready),
        .pc_hold         (pc_hold),
        .if_id_hold      (if_id_hold),
        .if_id_flush     (if_id_flush),
        .id_ex_hold      (id_ex_hold),
        .PL_stall        (PL_stall),
        .PL_flush        (PL_flush),
        .ex_mem_hold     (ex_mem_hold),
        .mem_wb_bubble   (mem_wb_bubble),
        .mem_timeout_err (mem_timeout_err)
`ifdef HAZARD_PERF_CNT_EN
        ,
        .perf_stall_cnt   (perf_stall_cnt),
        .perf_flush_cnt   (perf_flush_cnt),
        .perf_memwait_cnt (perf_memwait_cnt)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct packed {
        logic       rst_n;
        logic [4:0] rs1;
        logic       u1;
        logic [4:0] rs2;
        logic       u2;
        logic [4:0] rd;
        logic       mr;
        logic       redir;
        logic       mreq;
        logic       rdy;
    } stim_t;

    typedef struct {
        string       name;
        stim_t       s;
        logic [8:0]  exp;
    } vec_t;

    // Bit order: pc_hold, if_id_hold, if_id_flush, id_ex_hold, PL_stall, PL_flush, ex_mem_hold, mem_wb_bubble, err
    localparam logic [8:0] E_IDLE  = 9'b000000000;
    localparam logic [8:0] E_MEMH  = 9'b110100110;
    localparam logic [8:0] E_STALL = 9'b110010000;
    localparam logic [8:0] E_REDIR = 9'b001001000;
    localparam logic [8:0] E_FLUSH = 9'b001000000;
    localparam logic [8:0] E_ERR   = 9'b000000001;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_errors = 0;

    // Behavioural model: held dmem cycles so far, IF/ID flush cycles still owed, sticky error.
    int   m_wait;
    int   m_flush_left;
    logic m_err;
    logic m_live;
    int   m_cnt_stall, m_cnt_flush, m_cnt_memwait;

    function automatic stim_t st(input logic r, input logic [4:0] rs1, input logic u1,
                                 input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                                 input logic mr, input logic redir, input logic mreq, input logic rdy);
        stim_t s;
        s = '{rst_n: r, rs1: rs1, u1: u1, rs2: rs2, u2: u2, rd: rd, mr: mr,
              redir: redir, mreq: mreq, rdy: rdy};
        return s;
    endfunction

    task automatic add(input string name, input stim_t s, input logic [8:0] exp);
        vec_t v;
        v.name = name;
        v.s    = s;
        v.exp  = exp;
        vecs.push_back(v);
    endtask

    task automatic drive(input stim_t s);
        rst_n         = s.rst_n;
        Rs1_if_id     = s.rs1;
        rs1_used      = s.u1;
        Rs2_if_id     = s.rs2;
        rs2_used      = s.u2;
        Rd_id_ex      = s.rd;
        MemRead_id_ex = s.mr;
        ex_redirect   = s.redir;
        mem_req       = s.mreq;
        dmem_ready    = s.rdy;
    endtask

    function automatic logic [8:0] dut_vec();
        return {pc_hold, if_id_hold, if_id_flush, id_ex_hold, PL_stall, PL_flush,
                ex_mem_hold, mem_wb_bubble, mem_timeout_err};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s @%0t: got %b expected %b", name, $time, act, exp);
        end
    endtask

    task automatic apply(input stim_t s, input logic [8:0] exp, input string name);
        @(negedge clk);
        drive(s);
        #1;
        check(name, 32'(dut_vec()), 32'(exp));
    endtask

    task automatic model_step(input stim_t s, output logic [8:0] e);
        logic lu;
        e = E_IDLE;
        if (!s.rst_n) begin
            m_wait = 0; m_flush_left = 0; m_err = 1'b0; m_live = 1'b0;
            m_cnt_stall = 0; m_cnt_flush = 0; m_cnt_memwait = 0;
            return;
        end
        if (!m_live) begin
            m_live = 1'b1;
            return;
        end
        e[0] = m_err;
        if (m_wait > 0) m_cnt_memwait++;
        lu = s.mr && (s.rd != 0) && (((s.rd == s.rs1) && s.u1) || ((s.rd == s.rs2) && s.u2));
        if ((m_wait > 0) && !s.rdy && (m_wait < MEM_TIMEOUT)) begin
            e = e | E_MEMH;
            m_wait++;
        end else begin
            if ((m_wait > 0) && !s.rdy) m_err = 1'b1;
            if ((m_wait == 0) && s.mreq && !s.rdy) begin
                e = e | E_MEMH;
                m_wait = 1;
                m_flush_left = 0;
            end else begin
                m_wait = 0;
                if (s.redir) begin
                    e = e | E_REDIR;
                    m_flush_left = REDIRECT_HOLD;
                end else if (m_flush_left > 0) begin
                    e = e | E_FLUSH;
                    m_flush_left--;
                end else if (lu) begin
                    e = e | E_STALL;
                end
            end
        end
        if (e[4]) m_cnt_stall++;
        if (e[3]) m_cnt_flush++;
    endtask

    stim_t s_idle, s_miss, s_hit, s_redir, s_lu, s;
    logic [8:0] e;

    initial begin
        s_idle  = st(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        s_miss  = st(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        s_hit   = st(1, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        s_redir = st(1, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        s_lu    = st(1, 5, 1, 1, 1, 5, 1, 0, 0, 0);
        drive(st(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

        add("reset",            st(0, 0, 0, 0, 0, 0, 0, 0, 1, 0), E_IDLE);
        add("post_reset",       s_miss,  E_IDLE);
        add("idle",             s_idle,  E_IDLE);
        add("lu_rs1",           s_lu,    E_STALL);
        add("lu_bubble",        s_idle,  E_IDLE);
        add("lu_rd_x0",         st(1, 0, 1, 0, 0, 0, 1, 0, 0, 0), E_IDLE);
        add("lu_rs1_unused",    st(1, 7, 0, 3, 1, 7, 1, 0, 0, 0), E_IDLE);
        add("lu_rs2",           st(1, 2, 1, 9, 1, 9, 1, 0, 0, 0), E_STALL);
        add("no_load",          st(1, 0, 0, 9, 1, 9, 0, 0, 0, 0), E_IDLE);
        add("redir",            s_redir, E_REDIR);
        add("redir_hold1_lu",   s_lu,    E_FLUSH);
        add("redir_hold2",      s_idle,  E_FLUSH);
        add("redir_done",       s_idle,  E_IDLE);
        add("mw_enter",         s_miss,  E_MEMH);
        for (int i = 0; i < 3; i++)
            add("mw_hold_redir", st(1, 0, 0, 0, 0, 0, 0, 1, 1, 0), E_MEMH);
        add("mw_release_redir", st(1, 0, 0, 0, 0, 0, 0, 1, 1, 1), E_REDIR);
        add("mw_redir_hold1",   s_idle,  E_FLUSH);
        add("mw_redir_hold2",   s_idle,  E_FLUSH);
        add("mw_redir_done",    s_idle,  E_IDLE);
        add("prio_mem",         st(1, 5, 1, 1, 1, 5, 1, 1, 1, 0), E_MEMH);
        add("mw_ready",         s_hit,   E_IDLE);
        add("to_enter",         s_miss,  E_MEMH);
        for (int i = 0; i < MEM_TIMEOUT - 1; i++)
            add("to_hold", s_miss, E_MEMH);
        add("to_release",       s_miss,  E_IDLE);
        add("err_sticky1",      s_idle,  E_ERR);
        add("err_sticky2",      s_idle,  E_ERR);
        add("err_lu",           s_lu,    E_STALL | E_ERR);
        add("rst_mw_enter",     s_miss,  E_MEMH | E_ERR);
        add("rst_mw_hold",      s_miss,  E_MEMH | E_ERR);
        add("rst_in_mw",        st(0, 0, 0, 0, 0, 0, 0, 0, 1, 0), E_IDLE);
        add("rst_mw_post",      s_miss,  E_IDLE);
        add("rst_mw_run",       s_idle,  E_IDLE);
        add("rd_enter",         s_redir, E_REDIR);
        add("rst_in_rd",        st(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), E_IDLE);
        add("rst_rd_post",      s_redir, E_IDLE);
        add("rst_rd_run",       s_idle,  E_IDLE);
        add("rd_to_mw",         s_redir, E_REDIR);
        add("rd_mw_enter",      s_miss,  E_MEMH);
        add("rd_mw_ready",      s_hit,   E_IDLE);
        add("rd_mw_abandon",    s_idle,  E_IDLE);

        foreach (vecs[i]) begin
            model_step(vecs[i].s, e);
            apply(vecs[i].s, vecs[i].exp, vecs[i].name);
        end

        model_step(st(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), e);
        apply(st(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), e, "rand_reset");
        for (int i = 0; i < 3000; i++) begin
            int rdy_thr;
            rdy_thr  = ((i / 250) % 2 == 1) ? 1 : 6;
            s.rst_n  = ($urandom_range(0, 199) != 0);
            s.rs1    = 5'($urandom_range(0, 3));
            s.rs2    = 5'($urandom_range(0, 3));
            s.rd     = 5'($urandom_range(0, 3));
            s.u1     = 1'($urandom_range(0, 1));
            s.u2     = 1'($urandom_range(0, 1));
            s.mr     = 1'($urandom_range(0, 1));
            s.redir  = ($urandom_range(0, 7) == 0);
            s.mreq   = ($urandom_range(0, 9) < 4);
            s.rdy    = ($urandom_range(0, 9) < rdy_thr);
            model_step(s, e);
            apply(s, e, "rand");
        end

`ifdef HAZARD_PERF_CNT_EN
        @(posedge clk);
        #1;
        check("perf_stall",   perf_stall_cnt,   32'(m_cnt_stall));
        check("perf_flush",   perf_flush_cnt,   32'(m_cnt_flush));
        check("perf_memwait", perf_memwait_cnt, 32'(m_cnt_memwait));
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
